jk_mode_register: RTL and testbench
===================================

// Module: jk_mode_register
// PURPOSE
//  WIDTH-bit register built from per-bit JK cells. Runs in four selectable modes: hold, per-bit JK, up/down count and parallel load.
//  Successor to the single-bit JK storage element; generalises width and adds counting, load and wrap/overflow flags.
//  Used as a general control/status counter in the sequential-logic library.
// PARAMETERS
//  WIDTH    8              register width in bits (>=2)
//  MAX_VAL  2**WIDTH-1     count ceiling; COUNT mode wraps at this value (1..2**WIDTH-1)
// PORTS
//  clk      in   1      clock; all state changes on rising edge
//  rst      in   1      synchronous reset, active-high
//  en       in   1      cycle enable; 0 = all state (q, tc, ovf) holds, clr_ovf still honoured
//  mode     in   2      00 HOLD, 01 JK, 10 COUNT, 11 LOAD
//  j        in   WIDTH  per-bit J (JK mode only)
//  k        in   WIDTH  per-bit K (JK mode only)
//  up       in   1      COUNT direction: 1 up, 0 down
//  d        in   WIDTH  parallel load data (LOAD mode)
//  clr_ovf  in   1      clears sticky ovf
//  q        out  WIDTH  register value
//  tc       out  1      registered 1-cycle pulse: wrap occurred on the previous edge
//  ovf      out  1      sticky: set on any wrap, held until clr_ovf or rst
// BEHAVIOUR
//  - Reset (rst=1 at edge): q=0, tc=0, ovf=0; overrides en, mode, clr_ovf. Mid-count reset restarts from 0.
//  - All outputs registered; q/tc/ovf reflect the inputs sampled at the previous edge (latency 1).
//  - en=0: q holds; tc forced to 0 next cycle; ovf holds unless clr_ovf=1.
//  - HOLD: q holds, tc<=0.
//  - JK, per bit i: {j,k}=00 hold, 10 set, 01 clear, 11 toggle. No range check against MAX_VAL. tc<=0.
//  - LOAD: q<=d, unmodified, even when d>MAX_VAL. tc<=0.
//  - COUNT up:
//      q<MAX_VAL -> q+1.
//      q==MAX_VAL -> 0, with tc<=1 and ovf<=1.
//      q>MAX_VAL (after JK/LOAD) -> 0, with wrap flagged.
//  - COUNT down:
//      q>0 and q<=MAX_VAL -> q-1.
//      q==0 -> MAX_VAL, with wrap flagged.
//      q>MAX_VAL -> MAX_VAL, with wrap flagged.
//  - Arithmetic is WIDTH bits with no carry beyond WIDTH. When MAX_VAL=2**WIDTH-1, wrap equals natural overflow.
//  - ovf: wrap and clr_ovf in the same cycle -> ovf=1 (set wins). Otherwise clr_ovf=1 -> ovf=0.
//  - tc is a pulse: 1 for exactly the cycle after each wrap edge; consecutive wraps give consecutive pulses.
//  - Mode may change on any cycle; no pipeline state beyond q/tc/ovf, so a switch takes effect at the next edge.
// STRUCTURE
//  - Shared package jk_pkg:
//      mode localparams MODE_HOLD=2'b00, MODE_JK=2'b01, MODE_COUNT=2'b10, MODE_LOAD=2'b11;
//      JK code constants JK_HOLD/JK_CLR/JK_SET/JK_TGL.
//  - Sub-module jk_cell: 1-bit rising-edge JK flop with sync active-high rst and clock enable; instantiated WIDTH times (generate).
//  - Top level:
//      computes per-bit J/K from mode, so COUNT/LOAD map the target value onto set/clear codes: J=next&~q, K=~next&q;
//      next-value/wrap logic;
//      tc/ovf flops.
// TESTING
//  1 Reset: drive junk on all inputs, rst=1 for 1 edge -> q=0, tc=0, ovf=0. Repeat mid-count at q=5 -> q=0 next cycle.
//  2 JK, WIDTH=8: q=8'hF0, j=8'h0F, k=8'h3C (bits 5:4 clear, 3:2 toggle, 1:0 set) -> q=8'hCF; en=0 for the same inputs -> q unchanged.
//  3 COUNT up, WIDTH=4, MAX_VAL=9: from 0, 10 edges -> 1..9 then 0. tc=1 only the cycle q first reads 0; ovf=1 and stays.
//  4 COUNT down, MAX_VAL=9: LOAD 0 then count down -> 9, tc pulse. LOAD 4'hC then count up -> 0 with wrap; LOAD 4'hC then count down -> 9 with wrap.
//  5 ovf priority: wrap edge with clr_ovf=1 -> ovf=1. Next edge with clr_ovf=1 and no wrap -> ovf=0.
//  6 Default params (WIDTH=8, MAX_VAL=255): LOAD 8'hFF, count up -> 8'h00, tc=1; 300 random mode/j/k/d cycles checked against a reference model.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK mode register family: mode encodings and
// the two-bit {j,k} codes understood by a single JK cell.
package jk_pkg;

  // Operating modes of the register.
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_JK    = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Per-bit {j,k} codes.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Next value of one JK bit given its current value and {j,k} code.
  function automatic logic jk_next(input logic cur, input logic [1:0] code);
    logic nxt;
    nxt = cur;
    case (code)
      JK_HOLD: nxt = cur;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit rising-edge JK flop with synchronous active-high reset and a
// clock enable. The register instantiates one of these per bit.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);

  // Reset clears the bit; otherwise an enabled edge applies the JK code.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (ce) begin
      q <= jk_next(q, {j, k});
    end
  end

endmodule

// File: rtl/jk_mode_register.sv
// WIDTH-bit register built from JK cells with hold, per-bit JK, up/down
// count (wrapping at MAX_VAL) and parallel load modes. COUNT and LOAD are
// realised by translating the desired next value into set/clear codes for
// the cells, so every bit of state lives in a JK cell. tc pulses for one
// cycle after each wrap; ovf is sticky until cleared.
module jk_mode_register
  import jk_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] j_bits;
  logic [WIDTH-1:0] k_bits;
  logic             wrap;

  // Target value for COUNT/LOAD and the wrap condition; values above MAX_VAL
  // left behind by JK or LOAD are folded back into range with a wrap.
  always_comb begin
    next_q = q;
    wrap   = 1'b0;
    case (mode)
      MODE_COUNT: begin
        if (up) begin
          if (q >= MAX_Q) begin
            next_q = '0;
            wrap   = 1'b1;
          end else begin
            next_q = q + ONE_Q;
          end
        end else begin
          if ((q == '0) || (q > MAX_Q)) begin
            next_q = MAX_Q;
            wrap   = 1'b1;
          end else begin
            next_q = q - ONE_Q;
          end
        end
      end
      MODE_LOAD: begin
        next_q = d;
      end
      default: begin
        next_q = q;
        wrap   = 1'b0;
      end
    endcase
  end

  // JK mode passes j/k straight through; other modes set the bits that must
  // rise and clear the bits that must fall (HOLD yields all-zero codes).
  always_comb begin
    j_bits = '0;
    k_bits = '0;
    if (mode == MODE_JK) begin
      j_bits = j;
      k_bits = k;
    end else begin
      j_bits = next_q & ~q;
      k_bits = ~next_q & q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .ce  (en),
        .j   (j_bits[gi]),
        .k   (k_bits[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

  // Wrap flags: tc is a one-cycle pulse, ovf is sticky and set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= en & wrap;
      if (en && wrap) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jk_mode_register.sv
// Scoreboard bench for jk_mode_register: a 4-bit instance with MAX_VAL=9 and
// a default 8-bit instance. Drivers push hand-computed (or modelled)
// expectations into per-instance queues; monitors pop and compare on the
// falling edge after each active edge.
module tb_jk_mode_register;

  typedef struct packed {
    logic [7:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;

  // 4-bit, MAX_VAL=9 instance
  logic       a_rst = 1'b1, a_en = 1'b0, a_up = 1'b0, a_clr = 1'b0;
  logic [1:0] a_mode = 2'b00;
  logic [3:0] a_j = '0, a_k = '0, a_d = '0, a_q;
  logic       a_tc, a_ovf;

  // 8-bit default instance
  logic       b_rst = 1'b1, b_en = 1'b0, b_up = 1'b0, b_clr = 1'b0;
  logic [1:0] b_mode = 2'b00;
  logic [7:0] b_j = '0, b_k = '0, b_d = '0, b_q;
  logic       b_tc, b_ovf;

  exp_t  exp_a[$];
  exp_t  exp_b[$];
  string name_a[$];
  string name_b[$];

  int vectors     = 0;
  int miscompares = 0;

  jk_mode_register #(.WIDTH(4), .MAX_VAL(9)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .j(a_j), .k(a_k),
    .up(a_up), .d(a_d), .clr_ovf(a_clr), .q(a_q), .tc(a_tc), .ovf(a_ovf)
  );

  jk_mode_register dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .j(b_j), .k(b_k),
    .up(b_up), .d(b_d), .clr_ovf(b_clr), .q(b_q), .tc(b_tc), .ovf(b_ovf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs into the selected instance and queue the
  // expected outputs after the coming rising edge.
  task automatic applyStimulus(input int sel, input logic rst, input logic en,
                               input logic [1:0] mode, input logic [7:0] j,
                               input logic [7:0] k, input logic up,
                               input logic [7:0] d, input logic clr,
                               input logic [7:0] eq, input logic etc,
                               input logic eovf, input string name);
    exp_t e;
    e.q = eq; e.tc = etc; e.ovf = eovf;
    if (sel == 0) begin
      a_rst = rst; a_en = en; a_mode = mode; a_j = j[3:0]; a_k = k[3:0];
      a_up = up; a_d = d[3:0]; a_clr = clr;
    end else begin
      b_rst = rst; b_en = en; b_mode = mode; b_j = j; b_k = k;
      b_up = up; b_d = d; b_clr = clr;
    end
    @(posedge clk);
    if (sel == 0) begin
      exp_a.push_back(e); name_a.push_back(name);
    end else begin
      exp_b.push_back(e); name_b.push_back(name);
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] aq,
                             input logic atc, input logic aovf, input exp_t e);
    vectors++;
    if (aq !== e.q || atc !== e.tc || aovf !== e.ovf) begin
      miscompares++;
      $display("[TB] FAIL %s: got q=%0h tc=%0b ovf=%0b, expected q=%0h tc=%0b ovf=%0b",
               name, aq, atc, aovf, e.q, e.tc, e.ovf);
    end
  endtask

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (exp_a.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_a.pop_front();
      n = name_a.pop_front();
      checkOutput(n, {4'h0, a_q}, a_tc, a_ovf, e);
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (exp_b.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_b.pop_front();
      n = name_b.pop_front();
      checkOutput(n, b_q, b_tc, b_ovf, e);
    end
  end

  localparam logic [1:0] H = 2'b00, JK = 2'b01, C = 2'b10, L = 2'b11;

  initial begin
    logic [7:0] mq, nq, rj, rk, rd;
    logic       mt, mo, wrap, rrst, ren, rup, rclr;
    logic [1:0] rmode;

    // ---------------- 4-bit, MAX_VAL=9 ----------------
    applyStimulus(0, 1, 1, L, 8'hF, 8'hF, 1, 8'hF, 1, 8'h0, 0, 0, "a_reset_junk");
    for (int i = 1; i <= 5; i++)
      applyStimulus(0, 0, 1, C, 0, 0, 1, 0, 0, 8'(i), 0, 0, $sformatf("a_pre_up%0d", i));
    applyStimulus(0, 1, 1, C, 0, 0, 1, 0, 0, 8'h0, 0, 0, "a_midcount_reset");
    for (int i = 1; i <= 9; i++)
      applyStimulus(0, 0, 1, C, 0, 0, 1, 0, 0, 8'(i), 0, 0, $sformatf("a_up%0d", i));
    applyStimulus(0, 0, 1, C, 0, 0, 1, 0, 0, 8'h0, 1, 1, "a_up_wrap");
    applyStimulus(0, 0, 1, C, 0, 0, 1, 0, 0, 8'h1, 0, 1, "a_up_after_wrap");
    applyStimulus(0, 0, 1, L, 0, 0, 0, 8'h0, 0, 8'h0, 0, 1, "a_load0");
    applyStimulus(0, 0, 1, C, 0, 0, 0, 0, 0, 8'h9, 1, 1, "a_down_wrap");
    applyStimulus(0, 0, 1, C, 0, 0, 0, 0, 0, 8'h8, 0, 1, "a_down8");
    applyStimulus(0, 0, 1, L, 0, 0, 0, 8'hC, 0, 8'hC, 0, 1, "a_loadC_up");
    applyStimulus(0, 0, 1, C, 0, 0, 1, 0, 0, 8'h0, 1, 1, "a_above_max_up");
    applyStimulus(0, 0, 1, L, 0, 0, 0, 8'hC, 0, 8'hC, 0, 1, "a_loadC_down");
    applyStimulus(0, 0, 1, C, 0, 0, 0, 0, 0, 8'h9, 1, 1, "a_above_max_down");
    applyStimulus(0, 0, 1, H, 0, 0, 0, 0, 1, 8'h9, 0, 0, "a_hold_clr");
    applyStimulus(0, 0, 1, C, 0, 0, 1, 0, 1, 8'h0, 1, 1, "a_wrap_beats_clr");
    applyStimulus(0, 0, 1, C, 0, 0, 1, 0, 1, 8'h1, 0, 0, "a_clr_no_wrap");
    applyStimulus(0, 0, 1, L, 0, 0, 0, 8'h9, 0, 8'h9, 0, 0, "a_load9");
    applyStimulus(0, 0, 1, C, 0, 0, 1, 0, 0, 8'h0, 1, 1, "a_wrap_again");
    applyStimulus(0, 0, 0, C, 0, 0, 1, 0, 0, 8'h0, 0, 1, "a_en0_hold");
    applyStimulus(0, 0, 0, C, 0, 0, 1, 0, 1, 8'h0, 0, 0, "a_en0_clr");
    applyStimulus(0, 0, 1, JK, 8'hF, 8'h0, 0, 0, 0, 8'hF, 0, 0, "a_jk_no_range");

    // ---------------- 8-bit default ----------------
    applyStimulus(1, 1, 1, C, 8'hAA, 8'h55, 1, 8'h77, 1, 8'h00, 0, 0, "b_reset_junk");
    applyStimulus(1, 0, 1, L, 0, 0, 0, 8'hF0, 0, 8'hF0, 0, 0, "b_loadF0");
    applyStimulus(1, 0, 1, JK, 8'h0F, 8'h3C, 0, 0, 0, 8'hCF, 0, 0, "b_jk_mix");
    applyStimulus(1, 0, 0, JK, 8'h0F, 8'h3C, 0, 0, 0, 8'hCF, 0, 0, "b_jk_en0");
    applyStimulus(1, 0, 1, L, 0, 0, 0, 8'hFF, 0, 8'hFF, 0, 0, "b_loadFF");
    applyStimulus(1, 0, 1, C, 0, 0, 1, 0, 0, 8'h00, 1, 1, "b_up_wrap");
    applyStimulus(1, 0, 1, H, 0, 0, 0, 0, 1, 8'h00, 0, 0, "b_hold_clr");

    // Random cycles against a behavioural model.
    mq = 8'h00; mt = 1'b0; mo = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rrst  = ($urandom_range(0, 39) == 0);
      ren   = ($urandom_range(0, 3) != 0);
      rclr  = ($urandom_range(0, 3) == 0);
      rup   = 1'($urandom_range(0, 1));
      rmode = 2'($urandom_range(0, 3));
      rj    = 8'($urandom);
      rk    = 8'($urandom);
      rd    = 8'($urandom);
      if (rrst) begin
        mq = 8'h00; mt = 1'b0; mo = 1'b0;
      end else begin
        nq = mq;
        wrap = 1'b0;
        if (ren) begin
          if (rmode == JK) begin
            for (int b = 0; b < 8; b++) begin
              if (rj[b] && rk[b]) nq[b] = ~mq[b];
              else if (rj[b]) nq[b] = 1'b1;
              else if (rk[b]) nq[b] = 1'b0;
            end
          end else if (rmode == C) begin
            if (rup) begin
              if (mq == 8'd255) begin nq = 8'd0; wrap = 1'b1; end
              else nq = mq + 8'd1;
            end else begin
              if (mq == 8'd0) begin nq = 8'd255; wrap = 1'b1; end
              else nq = mq - 8'd1;
            end
          end else if (rmode == L) begin
            nq = rd;
          end
        end
        mt = wrap;
        if (wrap) mo = 1'b1;
        else if (rclr) mo = 1'b0;
        mq = nq;
      end
      applyStimulus(1, rrst, ren, rmode, rj, rk, rup, rd, rclr, mq, mt, mo,
                    $sformatf("b_rand%0d", i));
    end

    repeat (3) @(posedge clk);
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d/%0d pending, expected 0/0", exp_a.size(), exp_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
